// File: rtl/window_3x3_generator_pkg.sv
// Shared types and sizing helpers for the 3x3 window generator.
package window_3x3_generator_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } win_state_t;

    // Counter width for a dimension of n positions; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/window_3x3_generator_line_buffer.sv
// One-line delay: dout is the sample written DEPTH enabled steps earlier.
module window_3x3_generator_line_buffer
    import window_3x3_generator_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 640
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/window_3x3_generator.sv
// Streaming 3x3 raster window generator with clamp-to-edge borders.
//   state | meaning
//   FILL  | priming line buffers with the first IMG_WIDTH+1 pixels, no output
//   RUN   | every accepted pixel completes one window
//   FLUSH | input closed, remaining IMG_WIDTH+1 windows generated internally
module window_3x3_generator
    import window_3x3_generator_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_pixel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pixel_1,
    output logic [DATA_WIDTH-1:0] out_pixel_2,
    output logic [DATA_WIDTH-1:0] out_pixel_3,
    output logic [DATA_WIDTH-1:0] out_pixel_4,
    output logic [DATA_WIDTH-1:0] out_pixel_5,
    output logic [DATA_WIDTH-1:0] out_pixel_6,
    output logic [DATA_WIDTH-1:0] out_pixel_7,
    output logic [DATA_WIDTH-1:0] out_pixel_8,
    output logic [DATA_WIDTH-1:0] out_pixel_9,
    output logic                  out_sof,
    output logic                  out_eof
);

    localparam int CW = cnt_width(IMG_WIDTH);
    localparam int RW = cnt_width(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    win_state_t state, state_nx;

    logic [CW-1:0] in_col, win_col;
    logic [RW-1:0] in_row, win_row;

    logic accept, out_free, flush_step, load_win, shift;
    logic col_first, col_last, row_first, row_last;

    logic [DATA_WIDTH-1:0] new_px, mid_far, top_far;
    logic [DATA_WIDTH-1:0] bot_c, bot_l, mid_c, mid_l, top_c, top_l;
    logic [3*DATA_WIDTH-1:0] row_top, row_mid, row_bot;
    logic [9*DATA_WIDTH-1:0] win_nx;

    assign out_free   = !out_valid || out_ready;
    assign in_ready   = (state == FILL) || ((state == RUN) && out_free);
    assign accept     = in_valid && in_ready;
    // The eof window stays parked until handed off; no further steps after it.
    assign flush_step = (state == FLUSH) && (!out_valid || (out_ready && !out_eof));
    assign load_win   = ((state == RUN) && accept) || flush_step;
    assign shift      = accept || flush_step;
    assign new_px     = accept ? in_pixel : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            FILL: begin
                if (accept && (in_row == ROW_ONE) && (in_col == '0)) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (accept && (in_row == ROW_LAST) && (in_col == COL_LAST)) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                if (out_valid && out_ready && out_eof) begin
                    state_nx = FILL;
                end
            end
            default: state_nx = FILL;
        endcase
    end

    // Input counter tracks the pixel being accepted; window counter tracks the next centre.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_col  <= '0;
            in_row  <= '0;
            win_col <= '0;
            win_row <= '0;
        end else begin
            if (accept) begin
                if (in_col == COL_LAST) begin
                    in_col <= '0;
                    in_row <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
                end else begin
                    in_col <= in_col + 1'b1;
                end
            end
            if (load_win) begin
                if (win_col == COL_LAST) begin
                    win_col <= '0;
                    win_row <= (win_row == ROW_LAST) ? '0 : win_row + 1'b1;
                end else begin
                    win_col <= win_col + 1'b1;
                end
            end
        end
    end

    window_3x3_generator_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH)
    ) u_lb_mid (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (shift),
        .din   (new_px),
        .dout  (mid_far)
    );

    window_3x3_generator_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH)
    ) u_lb_top (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (shift),
        .din   (mid_far),
        .dout  (top_far)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bot_c <= '0;
            bot_l <= '0;
            mid_c <= '0;
            mid_l <= '0;
            top_c <= '0;
            top_l <= '0;
        end else if (shift) begin
            bot_c <= new_px;
            bot_l <= bot_c;
            mid_c <= mid_far;
            mid_l <= mid_c;
            top_c <= top_far;
            top_l <= top_c;
        end
    end

    function automatic logic [3*DATA_WIDTH-1:0] pick_cols(
        input logic [DATA_WIDTH-1:0] l,
        input logic [DATA_WIDTH-1:0] c,
        input logic [DATA_WIDTH-1:0] r,
        input logic                  first,
        input logic                  last
    );
        return {first ? c : l, c, last ? c : r};
    endfunction

    assign col_first = (win_col == '0);
    assign col_last  = (win_col == COL_LAST);
    assign row_first = (win_row == '0);
    assign row_last  = (win_row == ROW_LAST);

    // Out-of-frame rows (stale history or flush filler) are replaced by the centre row.
    assign row_mid = pick_cols(mid_l, mid_c, mid_far, col_first, col_last);
    assign row_top = row_first ? row_mid : pick_cols(top_l, top_c, top_far, col_first, col_last);
    assign row_bot = row_last  ? row_mid : pick_cols(bot_l, bot_c, new_px, col_first, col_last);
    assign win_nx  = {row_top, row_mid, row_bot};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_sof     <= 1'b0;
            out_eof     <= 1'b0;
            out_pixel_1 <= '0;
            out_pixel_2 <= '0;
            out_pixel_3 <= '0;
            out_pixel_4 <= '0;
            out_pixel_5 <= '0;
            out_pixel_6 <= '0;
            out_pixel_7 <= '0;
            out_pixel_8 <= '0;
            out_pixel_9 <= '0;
        end else if (load_win) begin
            out_valid   <= 1'b1;
            out_sof     <= row_first && col_first;
            out_eof     <= row_last && col_last;
            out_pixel_1 <= win_nx[9*DATA_WIDTH-1 -: DATA_WIDTH];
            out_pixel_2 <= win_nx[8*DATA_WIDTH-1 -: DATA_WIDTH];
            out_pixel_3 <= win_nx[7*DATA_WIDTH-1 -: DATA_WIDTH];
            out_pixel_4 <= win_nx[6*DATA_WIDTH-1 -: DATA_WIDTH];
            out_pixel_5 <= win_nx[5*DATA_WIDTH-1 -: DATA_WIDTH];
            out_pixel_6 <= win_nx[4*DATA_WIDTH-1 -: DATA_WIDTH];
            out_pixel_7 <= win_nx[3*DATA_WIDTH-1 -: DATA_WIDTH];
            out_pixel_8 <= win_nx[2*DATA_WIDTH-1 -: DATA_WIDTH];
            out_pixel_9 <= win_nx[DATA_WIDTH-1 -: DATA_WIDTH];
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
        end
    end

endmodule

// File: doc/window_3x3_generator.md
Name: window_3x3_generator

Overview:
- Streaming 3x3 neighbourhood generator for the transmission-estimation path.
- Accepts one raster-order 8-bit pixel per handshake and emits one 3x3 window per pixel.
- Each window is centred on pixel (r,c), with border replication (clamp) at all four frame edges.
- Output numbering matches the edge/weight estimators downstream:
  - 1..3 = row above (c-1, c, c+1)
  - 4..6 = centre row
  - 7..9 = row below

Parameters:
- DATA_WIDTH, 8, pixel width
- IMG_WIDTH, 640, pixels per line (>=3)
- IMG_HEIGHT, 480, lines per frame (>=3)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept a pixel this cycle
- in_pixel  in  DATA_WIDTH  raster-order pixel
- out_valid  out  1  window valid
- out_ready  in  1  consumer accepts window
- out_pixel_1 .. out_pixel_9  out  DATA_WIDTH each  window pixels, positions as in Overview
- out_sof  out  1  window centre is (0,0)
- out_eof  out  1  window centre is (IMG_HEIGHT-1, IMG_WIDTH-1)

Behaviour:
- Single clock domain, clk. rst_n is asynchronous active-low and fully resets state.
- Reset values: out_valid=0, all out_pixel_*=0, out_sof=0, out_eof=0, state=FILL, counters=0. in_ready=1 once rst_n deasserts.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out_* are held stable while out_valid && !out_ready.
- Raster index k = r*IMG_WIDTH + c. Window k is produced on acceptance of pixel k+IMG_WIDTH+1. It is registered: out_valid rises the next cycle (1-cycle latency).
- FSM:
  - FILL:
    - Accept IMG_WIDTH+1 pixels; produce no output.
    - in_ready=1.
    - -> RUN after the (IMG_WIDTH+1)th acceptance.
  - RUN:
    - Every acceptance produces one window.
    - in_ready = !out_valid || out_ready.
    - -> FLUSH when the last frame pixel (IMG_HEIGHT*IMG_WIDTH-1) is accepted.
  - FLUSH:
    - in_ready=0. The block self-generates the remaining IMG_WIDTH+1 windows, one per cycle when the output register is free.
    - -> FILL (counters cleared) on the handshake of the eof window.
- Clamping:
  - Neighbour column c-1 at c=0 uses c; c+1 at c=IMG_WIDTH-1 uses c.
  - Row r-1 at r=0 uses r; r+1 at r=IMG_HEIGHT-1 uses r.
  - Corners combine both rules.
- Storage: >= 2*IMG_WIDTH+3 pixels (two line buffers plus a 3-column shift register). No pixel is overwritten before its last use.
- Simultaneous events: in RUN, output handshake and new input acceptance in the same cycle are legal. The new window is loaded with no bubble, giving full throughput of 1 window/cycle.
- Back-to-back frames: the first pixel of frame N+1 is accepted only after frame N's eof window is handed off.
- out_sof / out_eof are asserted only alongside out_valid for the respective window.
- rst_n asserted mid-frame:
  - The partial frame is discarded and out_valid drops immediately (asynchronously).
  - The next accepted pixel is treated as pixel (0,0).
- Counters: column counter wraps IMG_WIDTH-1 -> 0 and increments the row; row wraps IMG_HEIGHT-1 -> 0 at end of frame.
- Width: counters are $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT) bits. No arithmetic is performed on pixel data.

Decomposition:
- Shared package holds:
  - DATA_WIDTH default
  - state encoding FILL/RUN/FLUSH
  - column/row counter width functions
- One natural sub-module, line_buffer: IMG_WIDTH-deep DATA_WIDTH delay line with an enable. Instantiated twice, advanced on input acceptance or on a FLUSH step.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=3, pixel(r,c)=10*r+c, out_ready=1 unless stated):
- Stream 12 pixels back-to-back:
  - no out_valid for the first 5 acceptances;
  - first window appears the cycle after the 6th;
  - window (0,0) = 0,0,1,0,0,1,10,10,11 with out_sof=1.
- Same frame, continued:
  - exactly 12 windows total;
  - window (2,3) = 12,13,13,22,23,23,22,23,23 with out_eof=1;
  - window (1,1) = 0,1,2,10,11,12,20,21,22;
  - in_ready=0 for the 5 FLUSH windows.
- Hold out_ready=0 for 3 cycles mid-RUN:
  - in_ready=0 and out_pixel_* stable for those cycles;
  - on release, the window sequence continues with none lost or duplicated.
- Two frames back-to-back with in_valid always high:
  - frame-2 window (0,0) = 0,0,1,0,0,1,10,10,11;
  - 24 windows total.
- Assert rst_n low after 7 input pixels, then restart the frame:
  - out_valid=0 asynchronously during reset;
  - the restarted frame produces the same 12 windows as the first scenario.
